// File: rtl/aib_tx_lane_mux.sv
// Per-channel master/slave TX source select with a small word-pair FIFO, zero-padded
// registered lane outputs, and a drain-then-gap sequence for safe source switching.
module aib_tx_lane_mux #(
  parameter int unsigned NumChn    = 1,
  parameter int unsigned AibIoCnt  = 20,
  parameter int unsigned LaneW     = 20,
  parameter int unsigned Depth     = 4,
  parameter int unsigned GapCycles = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NumChn-1:0]          c_ms_mode,
  input  logic [NumChn-1:0]          i_ms_valid,
  input  logic [NumChn*AibIoCnt-1:0] i_ms_data0,
  input  logic [NumChn*AibIoCnt-1:0] i_ms_data1,
  output logic [NumChn-1:0]          o_ms_ready,
  input  logic [NumChn-1:0]          i_sl_valid,
  input  logic [NumChn*AibIoCnt-1:0] i_sl_data0,
  input  logic [NumChn*AibIoCnt-1:0] i_sl_data1,
  output logic [NumChn-1:0]          o_sl_ready,
  input  logic [NumChn-1:0]          i_tx_en,
  output logic [NumChn-1:0]          o_tx_valid,
  output logic [NumChn*LaneW-1:0]    o_tx_data0,
  output logic [NumChn*LaneW-1:0]    o_tx_data1,
  output logic [NumChn-1:0]          o_busy,
  output logic [NumChn-1:0]          o_empty
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned GapW  = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam int unsigned PairW = 2 * AibIoCnt;
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [GapW-1:0] GapInit = GapW'(GapCycles - 1);

  typedef enum logic [1:0] {StRun, StDrain, StGap} state_e;

  for (genvar k = 0; k < NumChn; k++) begin : g_chn
    state_e             state_q, state_d;
    logic               cur_mode_q, cur_mode_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [PairW-1:0]   mem_q [Depth];
    logic               tx_valid_q, tx_valid_d;
    logic [LaneW-1:0]   tx_data0_q, tx_data0_d;
    logic [LaneW-1:0]   tx_data1_q, tx_data1_d;
    logic               full, empty, ms_ready, sl_ready, push, pop;
    logic [PairW-1:0]   wr_pair, head;

    always_comb begin
      full     = (cnt_q == DepthC);
      empty    = (cnt_q == '0);
      // Readies are masked during reset so no source sees a spurious accept.
      ms_ready = ~i_rst & (state_q == StRun) & cur_mode_q & ~full;
      sl_ready = ~i_rst & (state_q == StRun) & ~cur_mode_q & ~full;
      push     = cur_mode_q ? (i_ms_valid[k] & ms_ready) : (i_sl_valid[k] & sl_ready);
      wr_pair  = cur_mode_q ?
                 {i_ms_data1[k*AibIoCnt +: AibIoCnt], i_ms_data0[k*AibIoCnt +: AibIoCnt]} :
                 {i_sl_data1[k*AibIoCnt +: AibIoCnt], i_sl_data0[k*AibIoCnt +: AibIoCnt]};
      pop      = i_tx_en[k] & ~empty;
      head     = mem_q[rd_ptr_q];
    end

    always_comb begin
      state_d    = state_q;
      cur_mode_d = cur_mode_q;
      gap_d      = gap_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;

      unique case (state_q)
        StRun: begin
          if (c_ms_mode[k] != cur_mode_q) state_d = StDrain;
        end
        StDrain: begin
          if (empty) begin
            state_d = StGap;
            gap_d   = GapInit;
          end
        end
        StGap: begin
          // The mode is re-sampled only on gap exit; any later change re-enters DRAIN.
          if (gap_q == '0) begin
            cur_mode_d = c_ms_mode[k];
            state_d    = StRun;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: state_d = StRun;
      endcase

      tx_valid_d = pop;
      tx_data0_d = pop ? LaneW'(head[AibIoCnt-1:0])     : '0;
      tx_data1_d = pop ? LaneW'(head[PairW-1:AibIoCnt]) : '0;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q    <= StRun;
        cur_mode_q <= c_ms_mode[k];
        gap_q      <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        tx_valid_q <= 1'b0;
        tx_data0_q <= '0;
        tx_data1_q <= '0;
      end else begin
        state_q    <= state_d;
        cur_mode_q <= cur_mode_d;
        gap_q      <= gap_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        cnt_q      <= cnt_d;
        tx_valid_q <= tx_valid_d;
        tx_data0_q <= tx_data0_d;
        tx_data1_q <= tx_data1_d;
      end
    end

    // Storage needs no reset: the cleared pointers and count make old contents unreachable.
    always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_pair;
    end

    assign o_ms_ready[k]                 = ms_ready;
    assign o_sl_ready[k]                 = sl_ready;
    assign o_tx_valid[k]                 = tx_valid_q;
    assign o_tx_data0[k*LaneW +: LaneW]  = tx_data0_q;
    assign o_tx_data1[k*LaneW +: LaneW]  = tx_data1_q;
    assign o_busy[k]                     = (state_q != StRun);
    assign o_empty[k]                    = empty;
  end

endmodule
